// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - periodic serial ADC reader with power-of-two averaging
//
// Purpose: a period timer triggers a chip-select framed SCLK burst to an
// ADC081S021-style converter. The data bits of each frame are shifted in
// MSB-first and accumulated. Every 2^AVG_LOG2 frames the truncated mean is
// published on ADC_value_o with a one-cycle dataValid_STRB_o.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous reset, active-high
//   enable_i         sample-timer enable (0 also clears overrun_o)
//   samplePeriod_i   clk_i cycles between triggers, 0 = no triggers
//   adc_miso_i       serial data from the ADC
//   adc_cs_n_o       ADC chip select, active-low
//   adc_sclk_o       ADC serial clock, idle high
//   ADC_value_o      latest (averaged) sample
//   dataValid_STRB_o one-cycle strobe, ADC_value_o updated
//   busy_o           conversion frame in progress
//   overrun_o        sticky, a trigger arrived while not idle

module adc_spi_sampler #(
  parameter int ADC_BITWIDTH    = 8,
  parameter int CLK_DIV         = 4,
  parameter int FRAME_BITS      = 16,
  parameter int DATA_MSB_POS    = 3,
  parameter int AVG_LOG2        = 2,
  parameter int PERIOD_BITWIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [PERIOD_BITWIDTH-1:0] samplePeriod_i,
  input  logic                       adc_miso_i,
  output logic                       adc_cs_n_o,
  output logic                       adc_sclk_o,
  output logic [ADC_BITWIDTH-1:0]    ADC_value_o,
  output logic                       dataValid_STRB_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int ACC_W = ADC_BITWIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [PERIOD_BITWIDTH-1:0] PERIOD_ONE = PERIOD_BITWIDTH'(1);
  localparam logic [DIV_W-1:0]           DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0]           DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]           BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0]           BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]           DATA_FIRST = BIT_W'(DATA_MSB_POS);
  localparam logic [BIT_W-1:0]           DATA_LAST  = BIT_W'(DATA_MSB_POS + ADC_BITWIDTH - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]           CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t                       state_q;
  logic [PERIOD_BITWIDTH-1:0]   period_q, period_d;
  logic                         trigger;
  logic [DIV_W-1:0]             div_q;
  logic [BIT_W-1:0]             bit_q;
  logic [ADC_BITWIDTH-1:0]      shreg_q;
  logic [ACC_W-1:0]             acc_q;
  logic [ACC_W-1:0]             acc_sum;
  logic [CNT_W-1:0]             cnt_q;
  logic                         cs_n_q, sclk_q, strobe_q, busy_q, overrun_q;
  logic [ADC_BITWIDTH-1:0]      value_q;
  logic                         div_last;
  logic                         in_window;

  // Period timer: wraps in the trigger cycle, parked at 0 when disabled.
  always_comb begin
    trigger  = 1'b0;
    period_d = '0;
    if (enable_i && (samplePeriod_i != '0)) begin
      if (period_q == samplePeriod_i - PERIOD_ONE) begin
        trigger = 1'b1;
      end else begin
        period_d = period_q + PERIOD_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  assign div_last  = (div_q == DIV_LAST);
  assign in_window = (bit_q >= DATA_FIRST) && (bit_q <= DATA_LAST);
  // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
  assign acc_sum   = acc_q + ACC_W'(shreg_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      value_q   <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (!enable_i) begin
        overrun_q <= 1'b0;
      end else if (trigger && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q <= S_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        S_SETUP: begin
          if (div_last) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            state_q <= S_LOW;
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        S_LOW: begin
          if (div_last) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= S_HIGH;
            // MISO was driven on the falling edge and is stable by the rising one.
            if (in_window) begin
              shreg_q <= {shreg_q[ADC_BITWIDTH-2:0], adc_miso_i};
            end
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        S_HIGH: begin
          if (div_last) begin
            div_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= S_DONE;
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              bit_q   <= bit_q + BIT_ONE;
              sclk_q  <= 1'b0;
              state_q <= S_LOW;
            end
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (cnt_q == CNT_LAST) begin
            value_q  <= acc_sum[ACC_W-1:AVG_LOG2];
            strobe_q <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_cs_n_o       = cs_n_q;
  assign adc_sclk_o       = sclk_q;
  assign ADC_value_o      = value_q;
  assign dataValid_STRB_o = strobe_q;
  assign busy_o           = busy_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - bench for adc_spi_sampler, AVG_LOG2=0 and AVG_LOG2=2 instances

module tb_adc_spi_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] period = 16'd0;
  logic [1:0]  miso_v = 2'b00;

  logic        cs0, cs2, sclk0, sclk2, strb0, strb2, busy0, busy2, ovr0, ovr2;
  logic [7:0]  val0, val2;
  logic [1:0]  cs_v, sclk_v, strb_v, busy_v, ovr_v;

  assign cs_v   = {cs2, cs0};
  assign sclk_v = {sclk2, sclk0};
  assign strb_v = {strb2, strb0};
  assign busy_v = {busy2, busy0};
  assign ovr_v  = {ovr2, ovr0};

  always #5 clk = ~clk;

  adc_spi_sampler #(.ADC_BITWIDTH(8), .CLK_DIV(4), .FRAME_BITS(16), .DATA_MSB_POS(3),
                    .AVG_LOG2(0), .PERIOD_BITWIDTH(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .samplePeriod_i(period),
    .adc_miso_i(miso_v[0]), .adc_cs_n_o(cs0), .adc_sclk_o(sclk0),
    .ADC_value_o(val0), .dataValid_STRB_o(strb0), .busy_o(busy0), .overrun_o(ovr0));

  adc_spi_sampler #(.ADC_BITWIDTH(8), .CLK_DIV(4), .FRAME_BITS(16), .DATA_MSB_POS(3),
                    .AVG_LOG2(2), .PERIOD_BITWIDTH(16)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .samplePeriod_i(period),
    .adc_miso_i(miso_v[1]), .adc_cs_n_o(cs2), .adc_sclk_o(sclk2),
    .ADC_value_o(val2), .dataValid_STRB_o(strb2), .busy_o(busy2), .overrun_o(ovr2));

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] data_tab [1024];

  // ADC behaviour: a new bit on every falling SCLK; non-data positions carry junk.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i >= 3 && i <= 10) return b[10-i];
    return 1'($urandom_range(0, 1));
  endfunction

  int         nfall [2];
  int         fidx [2];
  int         bidx [2];
  logic [1:0] pcs = 2'b11;
  logic [1:0] psclk = 2'b11;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pcs[k] && !cs_v[k]) begin
        fidx[k] = nfall[k];
        nfall[k]++;
        bidx[k] = 0;
      end
      if (!cs_v[k] && psclk[k] && !sclk_v[k]) begin
        miso_v[k] = frame_bit(data_tab[fidx[k] & 1023], bidx[k]);
        bidx[k]++;
      end
      pcs[k]   = cs_v[k];
      psclk[k] = sclk_v[k];
    end
  end

  // Reference model: frame timing from the trigger edge, averaging from a running sum.
  int          cyc = 0;
  bit          model_valid = 0;
  logic [15:0] m_pc = 16'd0;
  bit          m_act = 0;
  int          m_E = 0;
  int          m_fidx = 0;
  int          m_nframes = 0;
  int          sum2 = 0;
  int          n2 = 0;
  logic [7:0]  ev [2];
  logic        es [2];
  logic        eovr = 1'b0;

  always @(posedge clk) begin
    logic trig, busy;
    logic [7:0] b;
    int d;
    cyc++;
    if (rst) begin
      m_pc = 16'd0; m_act = 0; sum2 = 0; n2 = 0;
      ev[0] = 8'd0; ev[1] = 8'd0; es[0] = 1'b0; es[1] = 1'b0; eovr = 1'b0;
      model_valid = 1;
    end else begin
      es[0] = 1'b0; es[1] = 1'b0;
      d = cyc - m_E;
      if (m_act && d == 133) begin
        b = data_tab[m_fidx & 1023];
        ev[0] = b; es[0] = 1'b1;
        sum2 += int'(b); n2++;
        if (n2 == 4) begin
          ev[1] = 8'(sum2 / 4); es[1] = 1'b1; sum2 = 0; n2 = 0;
        end
      end
      trig = 1'b0;
      if (en && period != 16'd0) begin
        if (m_pc == period - 16'd1) begin trig = 1'b1; m_pc = 16'd0; end
        else m_pc = m_pc + 16'd1;
      end else begin
        m_pc = 16'd0;
      end
      busy = m_act && d >= 1 && d <= 133;
      if (!en) eovr = 1'b0;
      else if (trig && busy) eovr = 1'b1;
      if (trig && !busy) begin
        m_E = cyc; m_act = 1; m_fidx = m_nframes; m_nframes++;
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] exp_v, act_v;
    logic e_frame, e_sclk;
    int d;
    if (model_valid) begin
      d = cyc - m_E;
      e_frame = m_act && d >= 0 && d <= 131;
      e_sclk  = !(e_frame && d >= 4 && ((d - 4) % 8) < 4);
      for (int k = 0; k < 2; k++) begin
        exp_v = {!e_frame, e_sclk, e_frame, eovr, es[k], ev[k]};
        act_v = {cs_v[k], sclk_v[k], busy_v[k], ovr_v[k], strb_v[k], (k == 0) ? val0 : val2};
        n_checks++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL cycle %0d dut%0d {cs_n,sclk,busy,ovr,strb,value}: got %h expected %h",
                   cyc, (k == 0) ? 0 : 2, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs_fall();
    logic p;
    int ok;
    ok = 0;
    p = cs0;
    for (int i = 0; i < 400 && ok == 0; i++) begin
      @(negedge clk);
      if (p && !cs0) ok = 1;
      p = cs0;
    end
    chk("cs_fall_seen", ok, 1);
  endtask

  task automatic run(input int n, output int falls, output int s0, output int s2);
    logic p;
    falls = 0; s0 = 0; s2 = 0;
    p = cs0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (p && !cs0) falls++;
      p = cs0;
      if (strb0) s0++;
      if (strb2) s2++;
    end
  endtask

  initial begin
    int f, s0, s2, base;
    int cs_low, pulses, badw, w, strobe_at, sval;
    logic ps;

    for (int i = 0; i < 1024; i++) data_tab[i] = 8'($urandom_range(0, 255));
    rst = 1'b1; en = 1'b0; period = 16'd0;
    cycles(3);
    chk("reset_cs_n", int'(cs0), 1);
    chk("reset_sclk", int'(sclk0), 1);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_strobe", int'(strb0), 0);
    chk("reset_overrun", int'(ovr0), 0);
    chk("reset_value", int'(val0), 0);
    rst = 1'b0;

    // Single frame timing with AVG_LOG2=0
    data_tab[m_nframes & 1023] = 8'hA5;
    period = 16'd200; en = 1'b1;
    wait_cs_fall();
    cs_low = 1; pulses = 0; badw = 0; w = 0; strobe_at = -1; sval = -1;
    ps = sclk0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (!cs0) cs_low++;
      if (!sclk0) w++;
      if (!ps && sclk0) begin
        pulses++;
        if (w != 4) badw++;
        w = 0;
      end
      ps = sclk0;
      if (strb0 && strobe_at < 0) begin strobe_at = i; sval = int'(val0); end
    end
    en = 1'b0;
    chk("cs_low_cycles", cs_low, 132);
    chk("sclk_pulses", pulses, 16);
    chk("sclk_bad_widths", badw, 0);
    chk("strobe_after_cs_fall", strobe_at, 133);
    chk("value_a5", sval, 8'hA5);
    chk("model_value_a5", int'(ev[0]), 8'hA5);
    rst = 1'b1; cycles(2); rst = 1'b0;

    // Averaging of 100..103
    base = m_nframes;
    for (int i = 0; i < 4; i++) data_tab[(base + i) & 1023] = 8'(100 + i);
    en = 1'b1;
    run(950, f, s0, s2);
    en = 1'b0;
    chk("avg_frames", f, 4);
    chk("avg_plain_strobes", s0, 4);
    chk("avg_strobes", s2, 1);
    chk("avg_value", int'(val2), 101);
    chk("model_avg_value", int'(ev[1]), 101);

    // Full scale then zero
    cycles(2);
    base = m_nframes;
    for (int i = 0; i < 4; i++) data_tab[(base + i) & 1023] = 8'hFF;
    en = 1'b1;
    run(950, f, s0, s2);
    en = 1'b0;
    chk("avg_ff_value", int'(val2), 255);
    chk("avg_ff_strobes", s2, 1);
    cycles(2);
    base = m_nframes;
    for (int i = 0; i < 4; i++) data_tab[(base + i) & 1023] = 8'h00;
    en = 1'b1;
    run(950, f, s0, s2);
    en = 1'b0;
    chk("avg_zero_value", int'(val2), 0);
    chk("avg_zero_strobes", s2, 1);

    // Period shorter than a frame
    cycles(2);
    period = 16'd100; en = 1'b1;
    f = 0;
    ps = cs0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (ps && !cs0) f++;
      ps = cs0;
      if (i == 198) chk("overrun_before_2nd", int'(ovr0), 0);
      if (i == 199) chk("overrun_on_2nd", int'(ovr0), 1);
    end
    chk("overrun_frames", f, 2);
    en = 1'b0;
    @(negedge clk);
    chk("overrun_cleared0", int'(ovr0), 0);
    chk("overrun_cleared2", int'(ovr2), 0);

    // Reset during bit 7, averaging state of dut2 holds two frames here
    cycles(2);
    period = 16'd200; en = 1'b1;
    wait_cs_fall();
    cycles(61);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", int'(cs0), 1);
    chk("abort_sclk", int'(sclk0), 1);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_value0", int'(val0), 0);
    chk("abort_value2", int'(val2), 0);
    rst = 1'b0;
    base = m_nframes;
    for (int i = 0; i < 4; i++) data_tab[(base + i) & 1023] = 8'(8'h40 + i);
    run(950, f, s0, s2);
    en = 1'b0;
    chk("after_abort_value0", int'(val0), 8'h43);
    chk("after_abort_value2", int'(val2), 8'h41);
    chk("after_abort_strobes2", s2, 1);

    // Enable dropped mid-frame
    cycles(2);
    data_tab[m_nframes & 1023] = 8'h5A;
    en = 1'b1;
    wait_cs_fall();
    cycles(50);
    en = 1'b0;
    run(200, f, s0, s2);
    chk("drop_en_strobes", s0, 1);
    chk("drop_en_value", int'(val0), 8'h5A);
    run(400, f, s0, s2);
    chk("drop_en_no_frames", f, 0);

    // Zero period
    period = 16'd0; en = 1'b1;
    run(500, f, s0, s2);
    chk("zero_period_frames", f, 0);
    en = 1'b0;

    // Randomised segments
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 7) == 0) period = 16'($urandom_range(0, 3));
      else period = 16'($urandom_range(100, 300));
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 14) == 0);
      cycles(1);
      rst = 1'b0;
      cycles($urandom_range(50, 600));
    end
    en = 1'b0;
    cycles(150);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
